// File: rtl/dispatch_scheduler_pkg.sv
// Dispatch scheduler shared types.
// Commit ID width and sequencer state encodings.
package dispatch_scheduler_pkg;

  localparam int COMMIT_ID_WIDTH = 8;

  typedef logic [COMMIT_ID_WIDTH-1:0] commit_id_t;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ISSUE = 2'd1,
    SCHED_DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/dispatch_scheduler_commit_window_tracker.sv
// In-flight window tracker: issued minus committed IDs,
// modulo the commit ID space.
module commit_window_tracker
  import dispatch_scheduler_pkg::*;
#(
  parameter int MAX_INFLIGHT = 8
) (
  input  commit_id_t i_issue_id,
  input  commit_id_t i_next_id,
  output logic       o_window_open,
  output logic       o_drained
);

  localparam commit_id_t LIMIT =
    commit_id_t'(MAX_INFLIGHT);

  commit_id_t w_outstanding;

  assign w_outstanding = i_issue_id - i_next_id;
  assign o_window_open = w_outstanding < LIMIT;
  assign o_drained     = w_outstanding == '0;

endmodule

// File: rtl/dispatch_scheduler.sv
// Per-sample block sequencer with bounded in-flight window.
// DISPATCH_OVERRUN_COUNT_EN adds a saturating overrun_count.
module dispatch_scheduler
  import dispatch_scheduler_pkg::*;
#(
  parameter  int n_blocks     = 256,
  parameter  int MAX_INFLIGHT = 8,
  localparam int BW           = $clog2(n_blocks),
  localparam int LW           = BW + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       sample_tick,
  input  logic [LW-1:0]              n_blocks_active,
  input  logic [COMMIT_ID_WIDTH-1:0] next_commit_id,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [BW-1:0]              issue_block,
  output logic [COMMIT_ID_WIDTH-1:0] issue_commit_id,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun,
  input  logic                       overrun_clear
`ifdef DISPATCH_OVERRUN_COUNT_EN
  ,
  output logic [15:0]                overrun_count
`endif
);

  sched_state_t r_state;
  sched_state_t w_state_nxt;
  logic [LW-1:0] r_len;
  logic [BW-1:0] r_block;
  commit_id_t    r_id;
  logic          r_done;
  logic          r_ovr;

  logic          w_window_open;
  logic          w_drained;
  logic          w_fire;
  logic          w_last;
  logic          w_idle_tick;
  logic          w_ovr_tick;
  logic [LW-1:0] w_len_in;

  commit_window_tracker #(
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) u_window (
    .i_issue_id   (r_id),
    .i_next_id    (next_commit_id),
    .o_window_open(w_window_open),
    .o_drained    (w_drained)
  );

  assign w_len_in =
    (n_blocks_active > LW'(n_blocks)) ?
    LW'(n_blocks) : n_blocks_active;

  assign w_fire      = issue_valid & issue_ready;
  assign w_last      = {1'b0, r_block} == (r_len - 1'b1);
  assign w_idle_tick = enable & sample_tick &
                       (r_state == SCHED_IDLE);
  // Ticks while a sample is still in flight only flag.
  assign w_ovr_tick  = enable & sample_tick &
                       (r_state != SCHED_IDLE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= SCHED_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (enable) begin
      unique case (r_state)
        SCHED_IDLE:
          if (sample_tick && w_len_in != '0)
            w_state_nxt = SCHED_ISSUE;
        SCHED_ISSUE:
          if (w_fire && w_last)
            w_state_nxt = SCHED_DRAIN;
        SCHED_DRAIN:
          if (w_drained)
            w_state_nxt = SCHED_IDLE;
        default:
          w_state_nxt = SCHED_IDLE;
      endcase
    end
  end

  always_comb begin
    issue_valid = 1'b0;
    busy        = r_state != SCHED_IDLE;
    if (r_state == SCHED_ISSUE)
      issue_valid = enable & w_window_open &
                    ~sample_tick;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len   <= '0;
      r_block <= '0;
      r_id    <= '0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_done <= (w_idle_tick & (w_len_in == '0)) |
                (enable & w_drained &
                 (r_state == SCHED_DRAIN));
      if (w_idle_tick) begin
        r_len   <= w_len_in;
        r_block <= '0;
      end else if (w_fire) begin
        r_block <= r_block + 1'b1;
        r_id    <= r_id + 1'b1;
      end
      if (w_ovr_tick)         r_ovr <= 1'b1;
      else if (overrun_clear) r_ovr <= 1'b0;
    end
  end

  assign issue_block     = r_block;
  assign issue_commit_id = r_id;
  assign done            = r_done;
  assign overrun         = r_ovr;

`ifdef DISPATCH_OVERRUN_COUNT_EN
  logic [15:0] r_ovr_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_ovr_cnt <= '0;
    else if (overrun_clear)
      r_ovr_cnt <= {15'd0, w_ovr_tick};
    else if (w_ovr_tick && r_ovr_cnt != '1)
      r_ovr_cnt <= r_ovr_cnt + 1'b1;
  end

  assign overrun_count = r_ovr_cnt;
`endif

endmodule
